// File: rtl/mod_check_scheduler.sv
// Round-robin shared serial residue engine: grants one requester word at a time, reduces it
// MSB-first modulo DIVISOR one bit per cycle, and returns remainder/divisible/id on a result port.
module mod_check_scheduler #(
   parameter int unsigned  NUM_REQ    = 4,
   parameter int unsigned  DATA_WIDTH = 8,
   parameter int unsigned  DIVISOR    = 3,
   localparam int unsigned RW         = $clog2(DIVISOR),
   localparam int unsigned IW         = $clog2(NUM_REQ)
) (
   input  logic                            clk,
   input  logic                            resetn,
   input  logic [NUM_REQ-1:0]              req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
   output logic [NUM_REQ-1:0]              req_ready,
   output logic                            res_valid,
   input  logic                            res_ready,
   output logic [IW-1:0]                   res_id,
   output logic [RW-1:0]                   res_rem,
   output logic                            res_div,
   output logic                            busy
);

   localparam int unsigned CW      = $clog2(DATA_WIDTH + 1);
   localparam int unsigned LastBit = DATA_WIDTH - 1;
   localparam int unsigned LastReq = NUM_REQ - 1;
   localparam logic [CW-1:0] CntLast   = LastBit[CW-1:0];
   localparam logic [IW-1:0] GrantInit = LastReq[IW-1:0];
   localparam logic [RW:0]   DivW      = DIVISOR[RW:0];

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [RW-1:0]         residue_q, residue_d;
   logic [IW-1:0]         last_grant_q, last_grant_d;
   logic [IW-1:0]         cur_id_q, cur_id_d;
   logic [IW-1:0]         res_id_q, res_id_d;
   logic [RW-1:0]         res_rem_q, res_rem_d;
   logic                  res_valid_q, res_valid_d;
   logic                  res_div_q, res_div_d;

   logic                  grant_found;
   logic [IW-1:0]         grant_idx;
   logic [DATA_WIDTH-1:0] grant_word;
   int unsigned           idx;
   logic [RW:0]           t, t_sub;
   logic [RW-1:0]         residue_next;

   // Search starts just after the last winner so a continuously valid requester cannot starve others.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      idx         = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         idx = (32'(last_grant_q) + 32'd1 + k) % NUM_REQ;
         if (!grant_found && req_valid[idx[IW-1:0]]) begin
            grant_found = 1'b1;
            grant_idx   = idx[IW-1:0];
         end
      end
      grant_word = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         if (grant_idx == k[IW-1:0]) grant_word = req_data[k*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      req_ready = '0;
      if (state_q == StIdle && grant_found) req_ready[grant_idx] = 1'b1;
   end

   // t < 2*DIVISOR, so a single conditional subtract keeps the residue reduced.
   always_comb begin
      t            = {residue_q, shreg_q[DATA_WIDTH-1]};
      t_sub        = t - DivW;
      residue_next = (t >= DivW) ? t_sub[RW-1:0] : t[RW-1:0];
   end

   always_comb begin
      state_d      = state_q;
      shreg_d      = shreg_q;
      cnt_d        = cnt_q;
      residue_d    = residue_q;
      last_grant_d = last_grant_q;
      cur_id_d     = cur_id_q;
      res_id_d     = res_id_q;
      res_rem_d    = res_rem_q;
      res_valid_d  = res_valid_q;
      res_div_d    = res_div_q;
      unique case (state_q)
         StIdle: begin
            if (grant_found) begin
               shreg_d      = grant_word;
               cur_id_d     = grant_idx;
               last_grant_d = grant_idx;
               residue_d    = '0;
               cnt_d        = '0;
               state_d      = StShift;
            end
         end
         StShift: begin
            residue_d = residue_next;
            shreg_d   = shreg_q << 1;
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
               state_d     = StDone;
               res_rem_d   = residue_next;
               res_div_d   = (residue_next == '0);
               res_id_d    = cur_id_q;
               res_valid_d = 1'b1;
            end
         end
         StDone: begin
            if (res_ready) begin
               res_valid_d = 1'b0;
               state_d     = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= StIdle;
         shreg_q      <= '0;
         cnt_q        <= '0;
         residue_q    <= '0;
         last_grant_q <= GrantInit;
         cur_id_q     <= '0;
         res_id_q     <= '0;
         res_rem_q    <= '0;
         res_valid_q  <= 1'b0;
         res_div_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         shreg_q      <= shreg_d;
         cnt_q        <= cnt_d;
         residue_q    <= residue_d;
         last_grant_q <= last_grant_d;
         cur_id_q     <= cur_id_d;
         res_id_q     <= res_id_d;
         res_rem_q    <= res_rem_d;
         res_valid_q  <= res_valid_d;
         res_div_q    <= res_div_d;
      end
   end

   assign res_valid = res_valid_q;
   assign res_id    = res_id_q;
   assign res_rem   = res_rem_q;
   assign res_div   = res_div_q;
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mod_check_scheduler.sv
// Bench for mod_check_scheduler: directed and random words checked against a round-robin and
// modulo reference model; a second instance covers DIVISOR=5.
module tb_mod_check_scheduler;

   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int DIV = 3;
   localparam int RW  = $clog2(DIV);
   localparam int IW  = $clog2(NR);
   localparam int RW5 = $clog2(5);

   logic              clk = 1'b0;
   logic              resetn = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*DW-1:0]  req_data = '0;
   logic [NR-1:0]     req_ready;
   logic              res_valid, res_div, busy;
   logic              res_ready = 1'b0;
   logic [IW-1:0]     res_id;
   logic [RW-1:0]     res_rem;

   logic [NR-1:0]     c5_valid = '0;
   logic [NR*DW-1:0]  c5_data = '0;
   logic [NR-1:0]     c5_ready;
   logic              c5_rv, c5_div, c5_busy;
   logic              c5_rr = 1'b0;
   logic [IW-1:0]     c5_id;
   logic [RW5-1:0]    c5_rem;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int prev_acc = 0;
   int model_last = NR - 1;

   mod_check_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DIVISOR(DIV)) dut (
      .clk(clk), .resetn(resetn), .req_valid(req_valid), .req_data(req_data),
      .req_ready(req_ready), .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
      .res_rem(res_rem), .res_div(res_div), .busy(busy)
   );

   mod_check_scheduler #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DIVISOR(5)) dut5 (
      .clk(clk), .resetn(resetn), .req_valid(c5_valid), .req_data(c5_data),
      .req_ready(c5_ready), .res_valid(c5_rv), .res_ready(c5_rr), .res_id(c5_id),
      .res_rem(c5_rem), .res_div(c5_div), .busy(c5_busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic int model_grant(input logic [NR-1:0] v);
      for (int k = 1; k <= NR; k++) if (v[(model_last + k) % NR]) return (model_last + k) % NR;
      return -1;
   endfunction

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic transact(input logic [NR-1:0] v, input logic [NR*DW-1:0] d, input int hold,
                           input bit b2b, output int g);
      logic [DW-1:0] w;
      int k, rem;
      req_valid = v;
      req_data  = d;
      res_ready = (hold == 0);
      g   = model_grant(v);
      w   = d[g*DW +: DW];
      rem = int'(w) % DIV;
      #1;
      check("idle_busy", busy, 0);
      check("grant_onehot", req_ready, 1 << g);
      if (b2b) check("accept_gap", cyc - prev_acc, DW + 2);
      prev_acc   = cyc;
      model_last = g;
      @(negedge clk);
      check("shift_ready_low", req_ready, 0);
      check("shift_busy", busy, 1);
      k = 1;
      while (res_valid !== 1'b1 && k < 4 * DW + 8) begin
         @(negedge clk);
         k++;
      end
      check("latency", k, DW + 1);
      check("res_id", res_id, g);
      check("res_rem", res_rem, rem);
      check("res_div", res_div, rem == 0);
      for (int i = 0; i < hold; i++) begin
         req_valid = '1;
         @(negedge clk);
         check("hold_valid", res_valid, 1);
         check("hold_id", res_id, g);
         check("hold_rem", res_rem, rem);
         check("hold_ready_low", req_ready, 0);
         check("hold_busy", busy, 1);
      end
      req_valid = '0;
      res_ready = 1'b1;
      @(negedge clk);
      check("post_hs_valid", res_valid, 0);
      check("post_hs_busy", busy, 0);
   endtask

   task automatic c5_word(input logic [DW-1:0] w);
      int k, rem;
      rem      = int'(w) % 5;
      c5_data  = {$urandom};
      c5_data[DW-1:0] = w;
      c5_valid = 4'b0001;
      c5_rr    = 1'b1;
      #1;
      check("c5_grant", c5_ready, 1);
      @(negedge clk);
      c5_valid = '0;
      k = 1;
      while (c5_rv !== 1'b1 && k < 4 * DW + 8) begin
         @(negedge clk);
         k++;
      end
      check("c5_latency", k, DW + 1);
      check("c5_rem", c5_rem, rem);
      check("c5_div", c5_div, rem == 0);
      check("c5_id", c5_id, 0);
      @(negedge clk);
      check("c5_post_valid", c5_rv, 0);
   endtask

   initial begin
      logic [NR*DW-1:0] d;
      logic [NR-1:0] m;
      int g;
      bit seen;

      repeat (2) @(negedge clk);
      check("rst_res_valid", res_valid, 0);
      check("rst_busy", busy, 0);
      check("rst_res_id", res_id, 0);
      check("rst_res_rem", res_rem, 0);
      check("rst_res_div", res_div, 0);
      check("rst_req_ready", req_ready, 0);
      resetn = 1'b1;
      @(negedge clk);

      d = {$urandom}; d[0*DW +: DW] = 8'd9;
      transact(4'b0001, d, 0, 1'b0, g);
      d = {$urandom}; d[2*DW +: DW] = 8'd200;
      transact(4'b0100, d, 0, 1'b0, g);
      d = {$urandom}; d[2*DW +: DW] = 8'd255;
      transact(4'b0100, d, 0, 1'b0, g);
      d = {$urandom}; d[3*DW +: DW] = 8'd0;
      transact(4'b1000, d, 0, 1'b0, g);
      d = {$urandom};
      transact(4'b0100, d, 5, 1'b0, g);

      // Abort a word mid-shift with reset; nothing may come out for it.
      req_valid = 4'b0010;
      req_data  = {$urandom};
      res_ready = 1'b1;
      #1;
      check("abort_grant", req_ready, 4'b0010);
      @(negedge clk);
      req_valid = '0;
      check("abort_busy", busy, 1);
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      #1;
      check("async_rst_busy", busy, 0);
      check("async_rst_valid", res_valid, 0);
      @(negedge clk);
      resetn = 1'b1;
      model_last = NR - 1;
      seen = 1'b0;
      repeat (DW + 4) begin
         @(negedge clk);
         if (res_valid !== 1'b0) seen = 1'b1;
      end
      check("no_ghost_result", seen, 0);

      for (int i = 0; i < 5; i++) begin
         d = {$urandom};
         transact('1, d, 0, i > 0, g);
         check("rotation_id", g, i % NR);
      end

      for (int i = 0; i < 20; i++) begin
         m = NR'($urandom_range(1, (1 << NR) - 1));
         d = {$urandom};
         transact(m, d, $urandom_range(0, 3), 1'b0, g);
      end

      c5_word(8'd123);
      c5_word(8'd0);
      for (int i = 0; i < 4; i++) c5_word(DW'($urandom));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
